// File: rtl/validator_pkg.sv
// Shared types and summary status codes for the multi-word result validator.
package validator_pkg;

    typedef enum logic [3:0] {
        VAL_IDLE,
        VAL_WAIT_DUT,
        VAL_READ_EXP,
        VAL_WAIT_DATA,
        VAL_COMPARE,
        VAL_WR_STATUS,
        VAL_WR_PASSCNT,
        VAL_WR_FIRSTFAIL,
        VAL_DONE
    } val_state_t;

    localparam logic [15:0] STATUS_PASS    = 16'h55AA;
    localparam logic [15:0] STATUS_FAIL    = 16'hDEAD;
    localparam logic [15:0] STATUS_TIMEOUT = 16'hBEEF;

endpackage

// File: rtl/val_tol_compare.sv
// Combinational tolerance compare: pass when |a - b| <= TOLERANCE, signed or unsigned.
module val_tol_compare #(
    parameter int DATA_WIDTH = 16,
    parameter int SIGNED_CMP = 1,
    parameter int TOLERANCE  = 0
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  pass
);

    localparam logic [DATA_WIDTH:0] TOL_V = (DATA_WIDTH+1)'(TOLERANCE);

    logic [DATA_WIDTH:0] ax, bx, diff, mag;

    // One extra bit makes the difference exact for both signed and unsigned operands.
    always_comb begin
        ax   = {(SIGNED_CMP != 0) ? a[DATA_WIDTH-1] : 1'b0, a};
        bx   = {(SIGNED_CMP != 0) ? b[DATA_WIDTH-1] : 1'b0, b};
        diff = ax - bx;
        mag  = diff[DATA_WIDTH] ? (~diff + 1'b1) : diff;
        pass = (mag <= TOL_V);
    end

endmodule

// File: rtl/validator_multi.sv
// Multi-word DUT result validator: fetches expected words from memory, compares within
// a tolerance and writes a status / pass-count / first-fail summary back to memory.
module validator_multi
    import validator_pkg::*;
#(
    parameter int ADDR_WIDTH     = 11,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_WORDS      = 8,
    parameter int EXP_BASE_ADDR  = 512,
    parameter int RES_BASE_ADDR  = 1000,
    parameter int MEM_LATENCY    = 1,
    parameter int TOLERANCE      = 0,
    parameter int SIGNED_CMP     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  dut_valid,
    input  logic [DATA_WIDTH-1:0] dut_data,
    output logic                  dut_ready,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic                  rd_en,
    output logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [DATA_WIDTH-1:0] data_to_mem,
    output logic                  busy,
    output logic                  val_done,
    output logic                  all_pass
);

    localparam int CW = $clog2(NUM_WORDS + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] NW_V     = CW'(NUM_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    if (DATA_WIDTH < 16 || NUM_WORDS < 1 || MEM_LATENCY < 1) begin : g_bad_param
        $error("validator_multi: DATA_WIDTH>=16, NUM_WORDS>=1, MEM_LATENCY>=1 required");
    end
    if (EXP_BASE_ADDR + NUM_WORDS - 1 >= 2**ADDR_WIDTH || RES_BASE_ADDR + 2 >= 2**ADDR_WIDTH) begin : g_bad_range
        $error("validator_multi: expected or summary region exceeds address space");
    end
    if (!(EXP_BASE_ADDR + NUM_WORDS - 1 < RES_BASE_ADDR || RES_BASE_ADDR + 2 < EXP_BASE_ADDR)) begin : g_bad_overlap
        $error("validator_multi: expected and summary regions overlap");
    end

    val_state_t state, state_next;

    logic [CW-1:0]         idx, pass_cnt, first_fail;
    logic [TW-1:0]         to_cnt;
    logic                  timed_out;
    logic [DATA_WIDTH-1:0] dut_reg;
    logic [MEM_LATENCY:0]  vld_pipe;
    logic                  cmp_pass, to_expire, lat_last;
    logic [15:0]           status_word;
    logic [ADDR_WIDTH-1:0] exp_addr;

    val_tol_compare #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGNED_CMP (SIGNED_CMP),
        .TOLERANCE  (TOLERANCE)
    ) u_cmp (
        .a    (dut_reg),
        .b    (mem_data_out),
        .pass (cmp_pass)
    );

    // vld_pipe[k] is high k cycles after the read strobe; bit MEM_LATENCY marks the compare cycle.
    assign lat_last  = vld_pipe[MEM_LATENCY-1];
    assign to_expire = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
    assign exp_addr  = ADDR_WIDTH'(EXP_BASE_ADDR) + ADDR_WIDTH'(idx);

    always_comb begin
        if (timed_out)
            status_word = STATUS_TIMEOUT;
        else if (first_fail != NW_V)
            status_word = STATUS_FAIL;
        else
            status_word = STATUS_PASS;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= VAL_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        dut_ready   = 1'b0;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        address_out = '0;
        data_to_mem = '0;
        busy        = 1'b1;
        val_done    = 1'b0;
        case (state)
            VAL_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_next = VAL_WAIT_DUT;
            end
            VAL_WAIT_DUT: begin
                dut_ready = 1'b1;
                if (dut_valid)
                    state_next = VAL_READ_EXP;
                else if (to_expire)
                    state_next = VAL_WR_STATUS;
            end
            VAL_READ_EXP: begin
                rd_en       = 1'b1;
                address_out = exp_addr;
                state_next  = lat_last ? VAL_COMPARE : VAL_WAIT_DATA;
            end
            VAL_WAIT_DATA: begin
                if (lat_last)
                    state_next = VAL_COMPARE;
            end
            VAL_COMPARE: begin
                state_next = (idx == LAST_IDX) ? VAL_WR_STATUS : VAL_WAIT_DUT;
            end
            VAL_WR_STATUS: begin
                wr_en       = 1'b1;
                address_out = ADDR_WIDTH'(RES_BASE_ADDR);
                data_to_mem = DATA_WIDTH'(status_word);
                state_next  = VAL_WR_PASSCNT;
            end
            VAL_WR_PASSCNT: begin
                wr_en       = 1'b1;
                address_out = ADDR_WIDTH'(RES_BASE_ADDR + 1);
                data_to_mem = DATA_WIDTH'(pass_cnt);
                state_next  = VAL_WR_FIRSTFAIL;
            end
            VAL_WR_FIRSTFAIL: begin
                wr_en       = 1'b1;
                address_out = ADDR_WIDTH'(RES_BASE_ADDR + 2);
                data_to_mem = DATA_WIDTH'(first_fail);
                state_next  = VAL_DONE;
            end
            VAL_DONE: begin
                busy       = 1'b0;
                val_done   = 1'b1;
                state_next = VAL_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = VAL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            pass_cnt   <= '0;
            first_fail <= NW_V;
            to_cnt     <= '0;
            timed_out  <= 1'b0;
            dut_reg    <= '0;
            vld_pipe   <= '0;
            all_pass   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[MEM_LATENCY-1:0], state_next == VAL_READ_EXP};

            if (state == VAL_IDLE && start) begin
                idx        <= '0;
                pass_cnt   <= '0;
                first_fail <= NW_V;
                timed_out  <= 1'b0;
                all_pass   <= 1'b0;
            end

            // Timeout window restarts each time a new word is awaited.
            if (state_next == VAL_WAIT_DUT && state != VAL_WAIT_DUT)
                to_cnt <= '0;
            else if (state == VAL_WAIT_DUT)
                to_cnt <= to_cnt + 1'b1;

            if (state == VAL_WAIT_DUT && dut_valid)
                dut_reg <= dut_data;

            if (state == VAL_WAIT_DUT && !dut_valid && to_expire)
                timed_out <= 1'b1;

            if (vld_pipe[MEM_LATENCY]) begin
                if (cmp_pass)
                    pass_cnt <= pass_cnt + 1'b1;
                else if (first_fail == NW_V)
                    first_fail <= idx;
                if (idx != LAST_IDX)
                    idx <= idx + 1'b1;
            end

            if (state == VAL_WR_FIRSTFAIL)
                all_pass <= !timed_out && (pass_cnt == NW_V);
        end
    end

endmodule
